// File: rtl/uart_cmd_slave.sv
// Responder end of the two-byte UART command link: decodes write/read frames into register strobes
// and answers reads with one byte. Define UART_CMD_SLAVE_TIMEOUT_EN to abandon stalled writes.
module uart_cmd_slave #(
    parameter int CLK_DIV    = 434,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
`ifdef UART_CMD_SLAVE_TIMEOUT_EN
    ,
    parameter int TO_BITS    = 20
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic                  tx,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy,
    output logic                  parity_err,
    output logic                  frame_err
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(CLK_DIV / 2);
    localparam logic [3:0]    TX_BITS = 4'(DATA_WIDTH + 2);

    localparam logic [2:0] R_IDLE  = 3'd0;
    localparam logic [2:0] R_START = 3'd1;
    localparam logic [2:0] R_DATA  = 3'd2;
    localparam logic [2:0] R_PAR   = 3'd3;
    localparam logic [2:0] R_STOP  = 3'd4;

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_WDATA = 3'd1;
    localparam logic [2:0] C_READ  = 3'd2;
    localparam logic [2:0] C_CAP   = 3'd3;
    localparam logic [2:0] C_TX    = 3'd4;

    logic                  rxMeta_q, rxSync_q, rxPrev_q;
    logic [2:0]            rState_q, rState_d;
    logic [CW-1:0]         rCnt_q, rCnt_d;
    logic [2:0]            rBit_q, rBit_d;
    logic [DATA_WIDTH-1:0] rShift_q, rShift_d;
    logic                  rPar_q, rPar_d;
    logic                  byteOk_q, byteOk_d;
    logic                  parErr_q, parErr_d;
    logic                  frmErr_q, frmErr_d;

    logic [2:0]            cState_q, cState_d;
    logic [ADDR_WIDTH-1:0] regAddr_q, regAddr_d;
    logic [DATA_WIDTH-1:0] regWdata_q, regWdata_d;
    logic                  regWe_q, regWe_d;
    logic [DATA_WIDTH+1:0] txShift_q, txShift_d;
    logic [CW-1:0]         txCnt_q, txCnt_d;
    logic [3:0]            txBit_q, txBit_d;
    logic                  tx_q, tx_d;
    logic                  inTx;

`ifdef UART_CMD_SLAVE_TIMEOUT_EN
    localparam int TO_LIMIT = TO_BITS * CLK_DIV;
    localparam int TW = $clog2(TO_LIMIT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TO_LIMIT - 1);
    logic [TW-1:0] toCnt_q, toCnt_d;
    logic          toPulse_q, toPulse_d;
`endif

    // Receive framer: data/parity/stop are sampled one full bit after the mid-start point.
    always_comb begin
        rState_d = rState_q;
        rCnt_d   = rCnt_q;
        rBit_d   = rBit_q;
        rShift_d = rShift_q;
        rPar_d   = rPar_q;
        byteOk_d = 1'b0;
        parErr_d = 1'b0;
        frmErr_d = 1'b0;
        case (rState_q)
            R_IDLE: begin
                if (rxPrev_q && !rxSync_q) begin
                    rState_d = R_START;
                    rCnt_d   = '0;
                end
            end
            R_START: begin
                if (rCnt_q == CNT_MID) begin
                    rCnt_d   = '0;
                    rBit_d   = '0;
                    rState_d = rxSync_q ? R_IDLE : R_DATA;
                end else begin
                    rCnt_d = rCnt_q + CW'(1);
                end
            end
            R_DATA: begin
                if (rCnt_q == CNT_MAX) begin
                    rCnt_d   = '0;
                    rShift_d = {rxSync_q, rShift_q[DATA_WIDTH-1:1]};
                    rBit_d   = rBit_q + 3'd1;
                    if (rBit_q == 3'(DATA_WIDTH - 1)) rState_d = R_PAR;
                end else begin
                    rCnt_d = rCnt_q + CW'(1);
                end
            end
            R_PAR: begin
                if (rCnt_q == CNT_MAX) begin
                    rCnt_d   = '0;
                    rPar_d   = rxSync_q;
                    rState_d = R_STOP;
                end else begin
                    rCnt_d = rCnt_q + CW'(1);
                end
            end
            R_STOP: begin
                if (rCnt_q == CNT_MAX) begin
                    rCnt_d   = '0;
                    rState_d = R_IDLE;
                    if (!rxSync_q)                frmErr_d = 1'b1;
                    else if (^{rShift_q, rPar_q}) byteOk_d = 1'b1;
                    else                          parErr_d = 1'b1;
                end else begin
                    rCnt_d = rCnt_q + CW'(1);
                end
            end
            default: rState_d = R_IDLE;
        endcase
    end

    assign inTx = (cState_q == C_TX);

    // Command sequencer; a receive error aborts any command except an in-flight response.
    always_comb begin
        cState_d   = cState_q;
        regAddr_d  = regAddr_q;
        regWdata_d = regWdata_q;
        regWe_d    = 1'b0;
        txShift_d  = txShift_q;
        txCnt_d    = txCnt_q;
        txBit_d    = txBit_q;
        tx_d       = tx_q;
`ifdef UART_CMD_SLAVE_TIMEOUT_EN
        toCnt_d    = toCnt_q;
        toPulse_d  = 1'b0;
`endif
        if ((parErr_q || frmErr_q) && !inTx) begin
            cState_d = C_IDLE;
        end else begin
            case (cState_q)
                C_IDLE: begin
                    if (byteOk_q) begin
                        regAddr_d = rShift_q[ADDR_WIDTH-1:0];
                        cState_d  = rShift_q[DATA_WIDTH-1] ? C_WDATA : C_READ;
`ifdef UART_CMD_SLAVE_TIMEOUT_EN
                        toCnt_d   = TW'(1);
`endif
                    end
                end
                C_WDATA: begin
                    if (byteOk_q) begin
                        regWdata_d = rShift_q;
                        regWe_d    = 1'b1;
                        cState_d   = C_IDLE;
                    end
`ifdef UART_CMD_SLAVE_TIMEOUT_EN
                    else if (toCnt_q == TO_MAX) begin
                        toPulse_d = 1'b1;
                        cState_d  = C_IDLE;
                    end else begin
                        toCnt_d = toCnt_q + TW'(1);
                    end
`endif
                end
                C_READ: cState_d = C_CAP;
                C_CAP: begin
                    txShift_d = {1'b1, ~^reg_rdata, reg_rdata};
                    txCnt_d   = '0;
                    txBit_d   = '0;
                    tx_d      = 1'b0;
                    cState_d  = C_TX;
                end
                C_TX: begin
                    if (txCnt_q == CNT_MAX) begin
                        txCnt_d = '0;
                        if (txBit_q == TX_BITS) begin
                            cState_d = C_IDLE;
                        end else begin
                            tx_d      = txShift_q[0];
                            txShift_d = {1'b1, txShift_q[DATA_WIDTH+1:1]};
                            txBit_d   = txBit_q + 4'd1;
                        end
                    end else begin
                        txCnt_d = txCnt_q + CW'(1);
                    end
                end
                default: cState_d = C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta_q   <= 1'b1;
            rxSync_q   <= 1'b1;
            rxPrev_q   <= 1'b1;
            rState_q   <= R_IDLE;
            rCnt_q     <= '0;
            rBit_q     <= '0;
            rShift_q   <= '0;
            rPar_q     <= 1'b0;
            byteOk_q   <= 1'b0;
            parErr_q   <= 1'b0;
            frmErr_q   <= 1'b0;
            cState_q   <= C_IDLE;
            regAddr_q  <= '0;
            regWdata_q <= '0;
            regWe_q    <= 1'b0;
            txShift_q  <= '1;
            txCnt_q    <= '0;
            txBit_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            rxMeta_q   <= rx;
            rxSync_q   <= rxMeta_q;
            rxPrev_q   <= rxSync_q;
            rState_q   <= rState_d;
            rCnt_q     <= rCnt_d;
            rBit_q     <= rBit_d;
            rShift_q   <= rShift_d;
            rPar_q     <= rPar_d;
            byteOk_q   <= byteOk_d;
            parErr_q   <= parErr_d;
            frmErr_q   <= frmErr_d;
            cState_q   <= cState_d;
            regAddr_q  <= regAddr_d;
            regWdata_q <= regWdata_d;
            regWe_q    <= regWe_d;
            txShift_q  <= txShift_d;
            txCnt_q    <= txCnt_d;
            txBit_q    <= txBit_d;
            tx_q       <= tx_d;
        end
    end

`ifdef UART_CMD_SLAVE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toCnt_q   <= '0;
            toPulse_q <= 1'b0;
        end else begin
            toCnt_q   <= toCnt_d;
            toPulse_q <= toPulse_d;
        end
    end
    assign frame_err = (frmErr_q && !inTx) || toPulse_q;
`else
    assign frame_err = frmErr_q && !inTx;
`endif

    assign tx         = tx_q;
    assign reg_addr   = regAddr_q;
    assign reg_wdata  = regWdata_q;
    assign reg_we     = regWe_q;
    assign reg_re     = (cState_q == C_READ);
    assign busy       = (cState_q != C_IDLE);
    assign parity_err = parErr_q && !inTx;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Directed bench for uart_cmd_slave at CLK_DIV=16; the timeout scenario runs on a second
// instance (TO_BITS=4) only when UART_CMD_SLAVE_TIMEOUT_EN is defined.
module tb_uart_cmd_slave;

    localparam int DIV  = 16;
    localparam int HIST = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] reg_rdata = 8'h00;
    logic       tx, reg_we, reg_re, busy, parity_err, frame_err;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;

    int   checkCount = 0;
    int   failCount  = 0;
    int   cyc = 0;
    int   weCount = 0, reCount = 0, bothCount = 0, parCount = 0, frmCount = 0;
    int   reCycle = 0;
    logic [6:0] weAddr = '0, reAddr = '0;
    logic [7:0] weData = '0;
    logic       reLast = 1'b0;
    logic       txHist [0:HIST-1];

    uart_cmd_slave #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy), .parity_err(parity_err), .frame_err(frame_err)
    );

`ifdef UART_CMD_SLAVE_TIMEOUT_EN
    logic       tx2, reg_we2, reg_re2, busy2, parity_err2, frame_err2, busyPrev2 = 1'b0;
    logic [6:0] reg_addr2;
    logic [7:0] reg_wdata2;
    int         busyRise2 = 0, busyFall2 = 0, frmCycle2 = 0, frmCount2 = 0, weCount2 = 0;

    uart_cmd_slave #(.CLK_DIV(DIV), .TO_BITS(4)) dutTo (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx2),
        .reg_addr(reg_addr2), .reg_wdata(reg_wdata2), .reg_we(reg_we2), .reg_re(reg_re2),
        .reg_rdata(reg_rdata), .busy(busy2), .parity_err(parity_err2), .frame_err(frame_err2)
    );
`endif

    always #5 clk = ~clk;

    // Observe strobes and the tx line on the falling edge; also plays the register bank,
    // presenting 0xA7 only in the cycle after reg_re.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cyc < HIST) txHist[cyc] = tx;
        if (reg_we) begin weCount++; weAddr = reg_addr; weData = reg_wdata; end
        if (reg_re) begin reCount++; reCycle = cyc; reAddr = reg_addr; end
        if (reg_we && reg_re) bothCount++;
        if (parity_err) parCount++;
        if (frame_err) frmCount++;
        reg_rdata = reLast ? 8'hA7 : 8'h00;
        reLast = reg_re;
`ifdef UART_CMD_SLAVE_TIMEOUT_EN
        if (busy2 && !busyPrev2) busyRise2 = cyc;
        if (!busy2 && busyPrev2) busyFall2 = cyc;
        if (frame_err2) begin frmCount2++; frmCycle2 = cyc; end
        if (reg_we2) weCount2++;
        busyPrev2 = busy2;
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic parFlip, input logic stopVal);
        logic [10:0] frame;
        frame = {stopVal, (~^data) ^ parFlip, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = frame[i];
            tick(DIV);
        end
        rx = 1'b1;
    endtask

    task automatic waitBusyLow(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick(1);
            n++;
        end
        checkOutput(tag, busy, 0);
    endtask

    initial begin
        logic [10:0] expFrame;
        int          base;
        int          n;
        int          weBefore2;
        int          frmBefore2;

        tick(5);
        checkOutput("rst_tx_during", tx, 1);
        rst_n = 1'b1;
        tick(3);
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_we_re", {reg_we, reg_re}, 0);
        checkOutput("rst_addr_wdata", {reg_addr, reg_wdata}, 0);
        checkOutput("rst_errs", {parity_err, frame_err}, 0);
        tick(10);

        $display("[TB] write 0x85 / 0x3C");
        applyStimulus(8'h85, 1'b0, 1'b1);
        checkOutput("wr_busy_between", busy, 1);
        applyStimulus(8'h3C, 1'b0, 1'b1);
        tick(20);
        checkOutput("wr_count", weCount, 1);
        checkOutput("wr_addr", weAddr, 7'h05);
        checkOutput("wr_data", weData, 8'h3C);
        checkOutput("wr_no_errs", parCount + frmCount, 0);
        checkOutput("wr_busy_after", busy, 0);

        $display("[TB] read 0x12");
        applyStimulus(8'h12, 1'b0, 1'b1);
        waitBusyLow("rd_busy_timeout", 400);
        tick(5);
        checkOutput("rd_re_count", reCount, 1);
        checkOutput("rd_addr", reAddr, 7'h12);
        checkOutput("rd_tx_high_T2", txHist[reCycle + 1], 1);
        checkOutput("rd_tx_fall_T3", txHist[reCycle + 2], 0);
        expFrame = 11'b1_0_1010_0111_0;
        base = reCycle + 2 + DIV / 2;
        for (int k = 0; k < 11; k++)
            checkOutput($sformatf("rd_tx_bit%0d", k), txHist[base + DIV * k], expFrame[k]);
        checkOutput("rd_no_write", weCount, 1);

        $display("[TB] bad parity 0x85 then 0x3C");
        applyStimulus(8'h85, 1'b1, 1'b1);
        applyStimulus(8'h3C, 1'b0, 1'b1);
        waitBusyLow("par_busy_timeout", 400);
        tick(5);
        checkOutput("par_err_count", parCount, 1);
        checkOutput("par_re_count", reCount, 2);
        checkOutput("par_re_addr", reAddr, 7'h3C);
        checkOutput("par_no_write", weCount, 1);

        $display("[TB] glitch then write 0x81 / 0xFF");
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(40);
        checkOutput("gl_no_errs", parCount * 16 + frmCount, 16);
        checkOutput("gl_busy", busy, 0);
        applyStimulus(8'h81, 1'b0, 1'b1);
        applyStimulus(8'hFF, 1'b0, 1'b1);
        tick(20);
        checkOutput("gl_we_count", weCount, 2);
        checkOutput("gl_we_addr", weAddr, 7'h01);
        checkOutput("gl_we_data", weData, 8'hFF);

        $display("[TB] stop bit low");
        applyStimulus(8'h85, 1'b0, 1'b0);
        tick(20);
        checkOutput("fr_err_count", frmCount, 1);
        checkOutput("fr_busy", busy, 0);
        checkOutput("fr_no_strobes", weCount * 16 + reCount, 34);
        checkOutput("fr_par_unchanged", parCount, 1);
        checkOutput("no_we_re_overlap", bothCount, 0);

        $display("[TB] reset during response");
        applyStimulus(8'h12, 1'b0, 1'b1);
        n = 0;
        while (tx && n < 200) begin
            tick(1);
            n++;
        end
        checkOutput("rt_tx_started", tx, 0);
        tick(40);
        rst_n = 1'b0;
        #1;
        checkOutput("rt_tx_idle", tx, 1);
        checkOutput("rt_busy", busy, 0);
        checkOutput("rt_addr", reg_addr, 0);
        tick(3);
        rst_n = 1'b1;
        tick(20);

`ifdef UART_CMD_SLAVE_TIMEOUT_EN
        $display("[TB] write address with no data byte");
        weBefore2  = weCount2;
        frmBefore2 = frmCount2;
        applyStimulus(8'h85, 1'b0, 1'b1);
        tick(100);
        checkOutput("to_frame_cycle", frmCycle2 - busyRise2, 63);
        checkOutput("to_busy_fall", busyFall2 - busyRise2, 63);
        checkOutput("to_frame_count", frmCount2 - frmBefore2, 1);
        checkOutput("to_busy_low", busy2, 0);
        checkOutput("to_no_write", weCount2 - weBefore2, 0);
`else
        weBefore2  = 0;
        frmBefore2 = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
